// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the register file with write scoreboard.
// Bypass is selected at build time with REG_FILE_BYPASS_EN.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
  } sb_entry_t;

  // Two-port pause codes kept for older decode stages: bit 0 = rs, bit 1 = rt
  typedef enum logic [1:0] {
    PAUSE_NO   = 2'b00,
    PAUSE_RS   = 2'b01,
    PAUSE_RT   = 2'b10,
    PAUSE_BOTH = 2'b11
  } pause_t;

  function automatic pause_t pause_code(input logic [1:0] hz);
    return pause_t'(hz);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus between the ID stage and the register file: read ports, issue, writeback and flush.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_hazard;
  logic [NUM_RD-1:0]        rd_used;
  logic                     stall;
  logic                     issue_valid;
  logic                     issue_we;
  logic [ADDR_W-1:0]        issue_rd;
  logic                     wb_we;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     flush;
  logic [31:0]              stall_cnt;

  modport master (
    output rd_addr, rd_used, issue_valid, issue_we, issue_rd,
           wb_we, wb_addr, wb_data, flush,
    input  rd_data, rd_hazard, stall, stall_cnt
  );

  modport slave (
    input  rd_addr, rd_used, issue_valid, issue_we, issue_rd,
           wb_we, wb_addr, wb_data, flush,
    output rd_data, rd_hazard, stall, stall_cnt
  );
endinterface

// File: rtl/reg_sb_track.sv
// In-flight destination tracker: a PIPE_DEPTH shift chain of {valid, addr} and per-port hazard compare.
module reg_sb_track #(
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int PIPE_DEPTH = 3,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_hazard
);
  // With write-through the last stage is being written this cycle, so it cannot hazard
  localparam int CMP_DEPTH = BYPASS ? PIPE_DEPTH - 1 : PIPE_DEPTH;

  logic [PIPE_DEPTH-1:0] sb_vld;
  logic [ADDR_W-1:0]     sb_addr [PIPE_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_vld <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) sb_addr[k] <= '0;
    end else begin
      for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
        sb_vld[k]  <= sb_vld[k-1] & ~flush;
        sb_addr[k] <= sb_addr[k-1];
      end
      sb_vld[0]  <= push & ~flush;
      sb_addr[0] <= push_addr;
    end
  end

  always_comb begin
    rd_hazard = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int k = 0; k < CMP_DEPTH; k++) begin
        if (rd_addr[i*ADDR_W +: ADDR_W] != '0 && sb_vld[k] &&
            sb_addr[k] == rd_addr[i*ADDR_W +: ADDR_W])
          rd_hazard[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with built-in write scoreboard for the ID stage.
// Define REG_FILE_BYPASS_EN for writeback-to-read write-through (one fewer stall cycle).
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_RD     = 2,
  parameter int PIPE_DEPTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  rf
);
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic              push;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 2**ADDR_W; j++) regs[j] <= '0;
    end else if (rf.wb_we && rf.wb_addr != '0) begin
      regs[rf.wb_addr] <= rf.wb_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    assign ra = rf.rd_addr[i*ADDR_W +: ADDR_W];
    always_comb begin
      rv = (ra == '0) ? '0 : regs[ra];
`ifdef REG_FILE_BYPASS_EN
      if (!rst && rf.wb_we && rf.wb_addr != '0 && rf.wb_addr == ra) rv = rf.wb_data;
`endif
    end
    assign rf.rd_data[i*DATA_W +: DATA_W] = rv;
  end

  // A stalled issue becomes a bubble; r0 destinations never occupy a slot
  assign rf.stall = |(rf.rd_hazard & rf.rd_used);
  assign push     = rf.issue_valid & ~rf.stall & rf.issue_we & (rf.issue_rd != '0);

  reg_sb_track #(
    .ADDR_W     (ADDR_W),
    .NUM_RD     (NUM_RD),
    .PIPE_DEPTH (PIPE_DEPTH),
    .BYPASS     (BYPASS)
  ) u_track (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (rf.issue_rd),
    .flush     (rf.flush),
    .rd_addr   (rf.rd_addr),
    .rd_hazard (rf.rd_hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              rf.stall_cnt <= '0;
    else if (rf.issue_valid && rf.stall)  rf.stall_cnt <= sat_inc(rf.stall_cnt);
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic against an issue-history model.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int PD = 3;
`ifdef REG_FILE_BYPASS_EN
  localparam int  CMP = PD - 1;
  localparam bit  BYP = 1'b1;
`else
  localparam int  CMP = PD;
  localparam bit  BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) rf ();

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PIPE_DEPTH(PD)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: architectural registers plus a history of accepted destinations with their issue cycle
  typedef struct { int addr; int cyc; } fl_t;
  fl_t         fl[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  int          cyc = 0;

  function automatic bit m_haz(int a);
    if (a == 0) return 1'b0;
    foreach (fl[j])
      if (fl[j].addr == a && cyc - fl[j].cyc >= 1 && cyc - fl[j].cyc <= CMP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NR-1:0] m_hazv();
    logic [NR-1:0] h = '0;
    for (int i = 0; i < NR; i++) h[i] = m_haz(int'(rf.rd_addr[i*AW +: AW]));
    return h;
  endfunction

  function automatic bit m_stall();
    return |(m_hazv() & rf.rd_used);
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (a == 0) return 32'd0;
    if (BYP && rf.wb_we && int'(rf.wb_addr) == a) return rf.wb_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 32; j++) m_regs[j] = 32'd0;
    fl.delete();
    m_cnt = 32'd0;
  endtask

  task automatic idle();
    rf.rd_addr = '0; rf.rd_used = '0; rf.issue_valid = 1'b0; rf.issue_we = 1'b0;
    rf.issue_rd = '0; rf.wb_we = 1'b0; rf.wb_addr = '0; rf.wb_data = '0; rf.flush = 1'b0;
  endtask

  // Advance one clock, applying the rules to the model using the inputs seen at the edge
  task automatic tick();
    bit s;
    fl_t e;
    s = m_stall();
    if (rf.issue_valid && s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (rf.flush) fl.delete();
    else if (rf.issue_valid && !s && rf.issue_we && rf.issue_rd != '0) begin
      e.addr = int'(rf.issue_rd); e.cyc = cyc; fl.push_back(e);
    end
    if (rf.wb_we && rf.wb_addr != '0) m_regs[rf.wb_addr] = rf.wb_data;
    @(posedge clk);
    cyc++;
    #1;
    while (fl.size() > 0 && cyc - fl[0].cyc > PD) fl.delete(0);
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k <= PD; k++) tick();
  endtask

  task automatic test_reset();
    idle();
    rf.rd_addr = {5'd7, 5'd3}; rf.rd_used = 2'b11;
    @(negedge clk);
    n_checks++; if (rf.rd_data !== '0)   begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rf.rd_data); end
    n_checks++; if (rf.rd_hazard !== '0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", rf.rd_hazard); end
    n_checks++; if (rf.stall !== 1'b0)   begin n_fail++; $display("FAIL reset_stall: got %b expected 0", rf.stall); end
    n_checks++; if (rf.stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", rf.stall_cnt); end
    tick();
  endtask

  task automatic test_hazard_wb();
    int stalls = 0;
    idle();
    rf.issue_valid = 1'b1; rf.issue_we = 1'b1; rf.issue_rd = 5'd5;
    @(negedge clk); tick();
    idle();
    rf.rd_addr = {5'd0, 5'd5}; rf.rd_used = 2'b01;
    for (int k = 1; k <= PD + 1; k++) begin
      rf.wb_we = (k == PD); rf.wb_addr = 5'd5; rf.wb_data = 32'hDEAD_BEEF;
      @(negedge clk);
      if (rf.stall === 1'b1) stalls++;
      n_checks++;
      if (rf.stall !== (k <= CMP)) begin
        n_fail++; $display("FAIL hazard_stall_cycle%0d: got %b expected %b", k, rf.stall, (k <= CMP));
      end
      if (k == PD + 1 || (BYP && k == PD)) begin
        n_checks++;
        if (rf.rd_data[DW-1:0] !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL hazard_readback_cycle%0d: got %h expected deadbeef", k, rf.rd_data[DW-1:0]);
        end
      end
      tick();
    end
    n_checks++;
    if (stalls != CMP) begin n_fail++; $display("FAIL hazard_stall_len: got %0d expected %0d", stalls, CMP); end
    drain();
  endtask

  task automatic test_r0();
    idle();
    rf.issue_valid = 1'b1; rf.issue_we = 1'b1; rf.issue_rd = 5'd0;
    @(negedge clk); tick();
    idle();
    rf.rd_addr = {5'd0, 5'd0}; rf.rd_used = 2'b01;
    rf.wb_we = 1'b1; rf.wb_addr = 5'd0; rf.wb_data = 32'h1234;
    @(negedge clk);
    n_checks++; if (rf.rd_hazard !== 2'b00) begin n_fail++; $display("FAIL r0_hazard: got %b expected 00", rf.rd_hazard); end
    n_checks++; if (rf.stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b expected 0", rf.stall); end
    n_checks++; if (rf.rd_data[DW-1:0] !== 32'd0) begin n_fail++; $display("FAIL r0_during_wb: got %h expected 0", rf.rd_data[DW-1:0]); end
    tick();
    rf.wb_we = 1'b0;
    @(negedge clk);
    n_checks++; if (rf.rd_data[DW-1:0] !== 32'd0) begin n_fail++; $display("FAIL r0_after_wb: got %h expected 0", rf.rd_data[DW-1:0]); end
    drain();
  endtask

  task automatic test_port1();
    idle();
    rf.issue_valid = 1'b1; rf.issue_we = 1'b1; rf.issue_rd = 5'd8;
    @(negedge clk); tick();
    rf.rd_addr = {5'd8, 5'd3}; rf.rd_used = 2'b01; rf.issue_rd = 5'd10;
    @(negedge clk);
    n_checks++; if (rf.rd_hazard !== 2'b10) begin n_fail++; $display("FAIL port1_hazard: got %b expected 10", rf.rd_hazard); end
    n_checks++; if (rf.stall !== 1'b0) begin n_fail++; $display("FAIL port1_stall: got %b expected 0", rf.stall); end
    tick();
    idle();
    rf.rd_addr = {5'd0, 5'd10};
    @(negedge clk);
    n_checks++; if (rf.rd_hazard[0] !== 1'b1) begin n_fail++; $display("FAIL port1_accepted: got %b expected 1", rf.rd_hazard[0]); end
    drain();
  endtask

  task automatic test_flush();
    idle();
    rf.issue_valid = 1'b1; rf.issue_we = 1'b1; rf.issue_rd = 5'd7;
    @(negedge clk); tick();
    @(negedge clk); tick();
    rf.issue_rd = 5'd9; rf.flush = 1'b1;
    @(negedge clk); tick();
    idle();
    rf.rd_addr = {5'd9, 5'd7};
    @(negedge clk);
    n_checks++; if (rf.rd_hazard !== 2'b00) begin n_fail++; $display("FAIL flush_hazard: got %b expected 00", rf.rd_hazard); end
    drain();
  endtask

  task automatic test_stall_cnt();
    logic [31:0] s0;
    int nst = 0;
    int guard = 0;
    s0 = m_cnt;
    idle();
    rf.rd_addr = {5'd0, 5'd12}; rf.rd_used = 2'b01;
    rf.issue_valid = 1'b1; rf.issue_we = 1'b1; rf.issue_rd = 5'd12;
    while (nst < 10 && guard < 100) begin
      @(negedge clk);
      if (m_stall()) nst++;
      n_checks++;
      if (rf.stall !== m_stall()) begin n_fail++; $display("FAIL cnt_stall: got %b expected %b", rf.stall, m_stall()); end
      tick();
      guard++;
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (rf.stall_cnt !== s0 + 32'd10) begin
      n_fail++; $display("FAIL stall_cnt_10: got %0d expected %0d", rf.stall_cnt, s0 + 32'd10);
    end
    drain();
    rf.issue_valid = 1'b1; rf.issue_we = 1'b1; rf.issue_rd = 5'd12;
    @(negedge clk); tick();
    idle();
    rf.rd_addr = {5'd0, 5'd12}; rf.rd_used = 2'b01;
    for (int k = 1; k <= CMP; k++) begin
      @(negedge clk);
      n_checks++; if (rf.stall !== 1'b1) begin n_fail++; $display("FAIL cnt_idle_stall%0d: got %b expected 1", k, rf.stall); end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (rf.stall_cnt !== s0 + 32'd10) begin
      n_fail++; $display("FAIL stall_cnt_hold: got %0d expected %0d", rf.stall_cnt, s0 + 32'd10);
    end
    drain();
  endtask

  task automatic test_random(int n);
    logic [NR-1:0] eh;
    logic [31:0]   ed;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NR; i++) rf.rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      rf.rd_used     = NR'($urandom);
      rf.issue_valid = 1'($urandom);
      rf.issue_we    = ($urandom_range(0, 3) != 0);
      rf.issue_rd    = AW'($urandom_range(0, 7));
      rf.wb_we       = 1'($urandom);
      rf.wb_addr     = AW'($urandom_range(0, 7));
      rf.wb_data     = $urandom;
      rf.flush       = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        ed = m_read(int'(rf.rd_addr[i*AW +: AW]));
        n_checks++;
        if (rf.rd_data[i*DW +: DW] !== ed) begin
          n_fail++; $display("FAIL rand_rd_data%0d cyc %0d: got %h expected %h", i, cyc, rf.rd_data[i*DW +: DW], ed);
        end
      end
      eh = m_hazv();
      n_checks++; if (rf.rd_hazard !== eh) begin n_fail++; $display("FAIL rand_hazard cyc %0d: got %b expected %b", cyc, rf.rd_hazard, eh); end
      n_checks++; if (rf.stall !== m_stall()) begin n_fail++; $display("FAIL rand_stall cyc %0d: got %b expected %b", cyc, rf.stall, m_stall()); end
      n_checks++; if (rf.stall_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_stall_cnt cyc %0d: got %0d expected %0d", cyc, rf.stall_cnt, m_cnt); end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    idle();
    rf.issue_valid = 1'b1; rf.issue_we = 1'b1;
    for (int k = 0; k < PD; k++) begin
      rf.issue_rd = AW'(3 + k);
      rf.wb_we = 1'b1; rf.wb_addr = AW'(1 + k); rf.wb_data = 32'hA500_0000 | k;
      @(negedge clk); tick();
    end
    idle();
    rf.rd_addr = {5'd3, 5'd1}; rf.rd_used = 2'b11; rf.issue_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (rf.stall !== m_stall()) begin n_fail++; $display("FAIL pre_reset_stall: got %b expected %b", rf.stall, m_stall()); end
    rst = 1'b1;
    #1;
    n_checks++; if (rf.rd_data !== '0)   begin n_fail++; $display("FAIL midrst_rd_data: got %h expected 0", rf.rd_data); end
    n_checks++; if (rf.rd_hazard !== '0) begin n_fail++; $display("FAIL midrst_hazard: got %b expected 0", rf.rd_hazard); end
    n_checks++; if (rf.stall !== 1'b0)   begin n_fail++; $display("FAIL midrst_stall: got %b expected 0", rf.stall); end
    n_checks++; if (rf.stall_cnt !== '0) begin n_fail++; $display("FAIL midrst_stall_cnt: got %0d expected 0", rf.stall_cnt); end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_hazard_wb();
    test_r0();
    test_port1();
    test_flush();
    test_stall_cnt();
    test_random(300);
    test_reset_mid();
    test_random(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
